lsm_sequencer: RTL and testbench

Multi-cycle sequencer for ARMv4 load/store multiple (LDM/STM) instructions. It is started by the state machine when the decoder flags an LSM-family instruction. It walks the 16-bit register list lowest-numbered register first, and drives the register-bank register counter, the memory address and the memory request handshake, one word per transfer. On completion it produces the written-back base address.

---
 rtl/lsm_sequencer.sv | 119 +++++++++++
 tb/tb_lsm_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lsm_sequencer.sv
// lsm_sequencer: walks an LDM/STM register list, driving the address, register number and memory handshake; LSM_WRITEBACK_EN enables base writeback
module lsm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic              p_bit,
  input  logic              u_bit,
  input  logic              l_bit,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        reg_counter,
  output logic              latch_reg,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [15:0]       list_q;
  logic [15:0]       list_nxt;
  logic              p_q;
  logic              u_q;
  logic              l_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        n;
  logic [ADDR_W-1:0] n4;
  logic [ADDR_W-1:0] start_addr;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign mem_req   = state == XFER;
  assign mem_we    = mem_req & ~l_q;
  assign latch_reg = mem_ack & mem_req & l_q;

  // Transfer count, lowest start address of the block, and the list with the serviced bit removed
  always_comb begin
    n          = popcount(list_q);
    n4         = ADDR_W'({n, 2'b00});
    start_addr = u_q ? (p_q ? base_q + ADDR_W'(4) : base_q)
                     : (p_q ? base_q - n4 : base_q - n4 + ADDR_W'(4));
    list_nxt   = list_q & ~(16'd1 << reg_counter);
  end

  // Sequencer state; outputs of a transfer only move on the edge that consumes mem_ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      list_q      <= '0;
      p_q         <= 1'b0;
      u_q         <= 1'b0;
      l_q         <= 1'b0;
      base_q      <= '0;
      mem_addr    <= '0;
      reg_counter <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= CALC;
          list_q <= reg_list;
          p_q    <= p_bit;
          u_q    <= u_bit;
          l_q    <= l_bit;
          base_q <= base_addr;
        end
        CALC: begin
          state       <= n == 5'd0 ? DONE : XFER;
          mem_addr    <= start_addr;
          reg_counter <= lowest(list_q);
        end
        XFER: if (mem_ack) begin
          list_q   <= list_nxt;
          mem_addr <= mem_addr + ADDR_W'(4);
          if (list_nxt == 16'd0) state <= DONE;
          else reg_counter <= lowest(list_nxt);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSM_WRITEBACK_EN
  logic [ADDR_W-1:0] wb_q;
  // Final base value is fixed once the list has been counted
  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else if (state == CALC) wb_q <= u_q ? base_q + n4 : base_q - n4;
  end
  assign wb_addr  = wb_q;
  assign wb_valid = done;
`else
  assign wb_addr  = '0;
  assign wb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lsm_sequencer.sv
// tb_lsm_sequencer: table-driven LDM/STM vectors with a transfer scoreboard plus reset and idle corner cases
module tb_lsm_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic        p_bit = 1'b0;
  logic        u_bit = 1'b0;
  logic        l_bit = 1'b0;
  logic [31:0] base_addr = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, mem_req, mem_we, latch_reg, wb_valid;
  logic [31:0] mem_addr, wb_addr;
  logic [3:0]  reg_counter;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        l, p, u;
    logic [15:0] list;
    logic [31:0] base;
    int          wt;
    logic [31:0] first;
    logic [31:0] wb;
    int          lat;
    bit          dstart;
  } vec_t;

  typedef struct {
    logic [3:0]  rc;
    logic [31:0] addr;
    logic        we;
  } xfer_t;

  xfer_t sb[$];
  vec_t  tbl[7];

  lsm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
    .p_bit(p_bit), .u_bit(u_bit), .l_bit(l_bit), .base_addr(base_addr),
    .mem_ack(mem_ack), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .reg_counter(reg_counter),
    .latch_reg(latch_reg), .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int    cyc, wcnt, k, lat_n;
    bit    seen;
    xfer_t e;
    k = 0;
    for (int r = 0; r < 16; r++) if (v.list[r]) begin
      e.rc   = 4'(r);
      e.addr = v.first + 32'(4 * k);
      e.we   = ~v.l;
      sb.push_back(e);
      k++;
    end
    @(negedge clk);
    start = 1'b1; reg_list = v.list; p_bit = v.p; u_bit = v.u; l_bit = v.l; base_addr = v.base;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; wcnt = 0; seen = 0; lat_n = 0;
    while (!seen && cyc < 100) begin
      mem_ack = 1'b0;
      if (v.dstart && cyc == 5) begin
        start = 1'b1; reg_list = 16'h0001; base_addr = '1; l_bit = ~v.l; p_bit = ~v.p;
      end else start = 1'b0;
      if (done) begin
        seen = 1;
        chk("done_latency", 32'(cyc), 32'(v.lat));
        chk("done_no_req", {31'd0, mem_req}, 32'd0);
`ifdef LSM_WRITEBACK_EN
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_addr", wb_addr, v.wb);
`else
        chk("wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("wb_addr", wb_addr, 32'd0);
`endif
      end else if (mem_req) begin
        if (sb.size() == 0) chk("extra_req", {31'd0, mem_req}, 32'd0);
        else begin
          chk("reg_counter", {28'd0, reg_counter}, {28'd0, sb[0].rc});
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
          if (wcnt == v.wt) begin
            mem_ack = 1'b1;
            wcnt = 0;
            #1;
            chk("latch_reg", {31'd0, latch_reg}, {31'd0, v.l});
            if (latch_reg) lat_n++;
            void'(sb.pop_front());
          end else begin
            wcnt++;
            #1;
            chk("latch_wait", {31'd0, latch_reg}, 32'd0);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    start = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("left_xfers", 32'(sb.size()), 32'd0);
    chk("latch_count", 32'(lat_n), v.l ? 32'(k) : 32'd0);
    chk("idle_after", {31'd0, busy}, 32'd0);
    sb.delete();
  endtask

  initial begin
    tbl[0] = '{l:0, p:0, u:1, list:16'h0006, base:32'h100, wt:0, first:32'h100, wb:32'h108, lat:4, dstart:0};
    tbl[1] = '{l:1, p:1, u:0, list:16'h8001, base:32'h200, wt:0, first:32'h1F8, wb:32'h1F8, lat:4, dstart:0};
    tbl[2] = '{l:1, p:1, u:1, list:16'h0010, base:32'h40, wt:3, first:32'h44, wb:32'h44, lat:6, dstart:0};
    tbl[3] = '{l:0, p:0, u:1, list:16'h0000, base:32'h80, wt:0, first:32'h0, wb:32'h80, lat:2, dstart:0};
    tbl[4] = '{l:0, p:0, u:0, list:16'hFFFF, base:32'h3C, wt:0, first:32'h0, wb:32'hFFFFFFFC, lat:18, dstart:1};
    tbl[5] = '{l:1, p:0, u:0, list:16'h00A0, base:32'h10, wt:1, first:32'hC, wb:32'h8, lat:6, dstart:0};
    tbl[6] = '{l:0, p:1, u:1, list:16'h0003, base:32'hFFFFFFFC, wt:0, first:32'h0, wb:32'h4, lat:4, dstart:0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_latch", {31'd0, latch_reg}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rc", {28'd0, reg_counter}, 32'd0);
    chk("rst_wb", wb_addr, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    begin
      bit dn;
      @(negedge clk);
      start = 1'b1; reg_list = 16'h0006; p_bit = 1'b0; u_bit = 1'b1; l_bit = 1'b0; base_addr = 32'h100;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      chk("rst_case_addr2", mem_addr, 32'h104);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      chk("mid_rst_addr", mem_addr, 32'd0);
      dn = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        dn |= done;
        if (busy) dn = 1;
      end
      chk("mid_rst_quiet", {31'd0, dn}, 32'd0);
      mem_ack = 1'b0;
    end

    run_vec(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
